// File: rtl/vdp1_color_pipe.sv
// VDP1 colour-calculation pipeline: three-stage Gouraud/blend datapath feeding a credit-managed output FIFO.
// Optional mesh-pixel dropping at S1 is enabled by defining VDP1_MESH_EN.
module vdp1_color_pipe #(
  parameter  int CW    = 5,
  parameter  int AW    = 18,
  parameter  int DEPTH = 4,
  localparam int PW    = 3*CW + 1,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce_i,
  input  logic            flush_i,
  input  logic            in_val_i,
  output logic            in_rdy_o,
  input  logic [PW-1:0]   in_orig_i,
  input  logic [PW-1:0]   in_back_i,
  input  logic [2:0]      in_ccb_i,
  input  logic            in_mon_i,
  input  logic            in_mesh_i,
  input  logic [1:0]      in_xy0_i,
  input  logic [3*CW-1:0] in_grd_i,
  input  logic [AW-1:0]   in_addr_i,
  output logic            out_val_o,
  input  logic            out_rdy_i,
  output logic [PW-1:0]   out_color_o,
  output logic [AW-1:0]   out_addr_o,
  output logic [LW-1:0]   level_o
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CRW  = LW + 2;
  localparam logic [CW+1:0] HALF = (CW+2)'(1 << (CW-1));
  localparam logic [CW+1:0] MAXV = (CW+2)'((1 << CW) - 1);

  function automatic logic [CW-1:0] gouraud_ch(input logic [CW-1:0] o, input logic [CW-1:0] g);
    logic [CW+1:0] s;
    logic [CW+1:0] d;
    s = {2'b00, o} + {2'b00, g};
    if (s < HALF) return '0;
    d = s - HALF;
    if (d > MAXV) return '1;
    return d[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] clamp_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction

  function automatic logic [PW-1:0] color_calc(input logic [2:0] ccb, input logic [PW-1:0] orig,
                                               input logic [PW-1:0] back, input logic [3*CW-1:0] og);
    logic [PW-1:0] res;
    logic [CW-1:0] o, k, g, a, b;
    logic          om, bm;
    om  = orig[PW-1];
    bm  = back[PW-1];
    res = '0;
    for (int c = 0; c < 3; c++) begin
      o = orig[c*CW +: CW];
      k = back[c*CW +: CW];
      g = og[c*CW +: CW];
      a = '0;
      b = '0;
      case (ccb)
        3'b000: a = o;
        3'b001: b = bm ? (k >> 1) : k;
        3'b010: a = o >> 1;
        3'b011: begin a = bm ? (o >> 1) : o; b = bm ? (k >> 1) : '0; end
        3'b100: a = g;
        3'b101: b = k;
        3'b110: a = g >> 1;
        default: begin a = bm ? (g >> 1) : g; b = bm ? (k >> 1) : '0; end
      endcase
      res[c*CW +: CW] = clamp_add(a, b);
    end
    case (ccb)
      3'b001, 3'b101: res[PW-1] = bm;
      3'b011, 3'b110: res[PW-1] = bm | om;
      default:        res[PW-1] = om;
    endcase
    return res;
  endfunction

  logic mesh_drop;
`ifdef VDP1_MESH_EN
  assign mesh_drop = in_mesh_i & (in_xy0_i[1] ^ in_xy0_i[0]);
`else
  logic unused_mesh;
  assign unused_mesh = ^{in_mesh_i, in_xy0_i};
  assign mesh_drop   = 1'b0;
`endif

  logic s1_v_q, s2_v_q, s3_v_q;
  logic [PW-1:0]   s1_orig_q, s1_back_q, s2_orig_q, s2_back_q, s3_color_q;
  logic [3*CW-1:0] s1_grd_q, s2_og_q, s2_og_d;
  logic [2:0]      s1_ccb_q, s2_ccb_q;
  logic            s1_mon_q, s2_mon_q;
  logic [AW-1:0]   s1_addr_q, s2_addr_q, s3_addr_q;
  logic [PW-1:0]   s3_color_d;

  logic accept, push, pop;
  assign accept = in_val_i & in_rdy_o & ce_i & ~flush_i;
  assign push   = s3_v_q & ce_i & ~flush_i;
  assign pop    = out_val_o & out_rdy_i & ce_i & ~flush_i;

  // NOTE: every combinational variable gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    s2_og_d = '0;
    for (int c = 0; c < 3; c++) begin
      s2_og_d[c*CW +: CW] = gouraud_ch(s1_orig_q[c*CW +: CW], s1_grd_q[c*CW +: CW]);
    end
  end

  assign s3_color_d = s2_mon_q ? (s2_back_q | {1'b1, {(PW-1){1'b0}}})
                               : color_calc(s2_ccb_q, s2_orig_q, s2_back_q, s2_og_q);

  // NOTE: sequential state uses non-blocking assignments so all stages advance on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0; s2_v_q <= 1'b0; s3_v_q <= 1'b0;
      s1_orig_q <= '0; s1_back_q <= '0; s1_grd_q <= '0; s1_ccb_q <= '0; s1_mon_q <= 1'b0; s1_addr_q <= '0;
      s2_orig_q <= '0; s2_back_q <= '0; s2_og_q <= '0; s2_ccb_q <= '0; s2_mon_q <= 1'b0; s2_addr_q <= '0;
      s3_color_q <= '0; s3_addr_q <= '0;
    end else if (ce_i) begin
      s1_v_q <= accept & ~mesh_drop;
      s2_v_q <= s1_v_q & ~flush_i;
      s3_v_q <= s2_v_q & ~flush_i;
      if (accept) begin
        s1_orig_q <= in_orig_i; s1_back_q <= in_back_i; s1_grd_q <= in_grd_i;
        s1_ccb_q  <= in_ccb_i;  s1_mon_q  <= in_mon_i;  s1_addr_q <= in_addr_i;
      end
      s2_orig_q <= s1_orig_q; s2_back_q <= s1_back_q; s2_og_q   <= s2_og_d;
      s2_ccb_q  <= s1_ccb_q;  s2_mon_q  <= s1_mon_q;  s2_addr_q <= s1_addr_q;
      s3_color_q <= s3_color_d;
      s3_addr_q  <= s2_addr_q;
    end
  end

  logic [PW+AW-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wptr_q, rptr_q;
  logic [LW-1:0]    count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (ce_i) begin
      if (flush_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        wptr_q  <= wptr_q + PTRW'(push);
        rptr_q  <= rptr_q + PTRW'(pop);
        count_q <= count_d;
      end
    end
  end

  // NOTE: storage is not reset; outputs are masked while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {s3_addr_q, s3_color_q};
  end

  logic [CRW-1:0]   credits;
  logic [PW+AW-1:0] head;
  assign credits     = CRW'(count_q) + CRW'(s1_v_q) + CRW'(s2_v_q) + CRW'(s3_v_q);
  assign in_rdy_o    = credits < CRW'(DEPTH);
  assign head        = mem_q[rptr_q];
  assign out_val_o   = (count_q != '0);
  assign out_color_o = out_val_o ? head[PW-1:0] : '0;
  assign out_addr_o  = out_val_o ? head[PW+AW-1:PW] : '0;
  assign level_o     = count_q;

endmodule

// File: tb/tb_vdp1_color_pipe.sv
// Scoreboard bench for vdp1_color_pipe: a recorder queues reference results on accept, a monitor checks pops.
module tb_vdp1_color_pipe;
  localparam int CW = 5, AW = 18, DEPTH = 4, PW = 16, LW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic ce = 1'b1, flush = 1'b0, in_val = 1'b0, in_mon = 1'b0, in_mesh = 1'b0, out_rdy = 1'b1;
  logic [PW-1:0] in_orig = '0, in_back = '0;
  logic [2:0] in_ccb = '0;
  logic [1:0] in_xy0 = '0;
  logic [3*CW-1:0] in_grd = '0;
  logic [AW-1:0] in_addr = '0;
  logic in_rdy, out_val;
  logic [PW-1:0] out_color;
  logic [AW-1:0] out_addr;
  logic [LW-1:0] level;

  logic [AW+PW-1:0] exp_q[$];
  int total = 0, bad = 0, pops = 0, accepts = 0;

  vdp1_color_pipe #(.CW(CW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ce_i(ce), .flush_i(flush), .in_val_i(in_val), .in_rdy_o(in_rdy),
    .in_orig_i(in_orig), .in_back_i(in_back), .in_ccb_i(in_ccb), .in_mon_i(in_mon), .in_mesh_i(in_mesh),
    .in_xy0_i(in_xy0), .in_grd_i(in_grd), .in_addr_i(in_addr), .out_val_o(out_val), .out_rdy_i(out_rdy),
    .out_color_o(out_color), .out_addr_o(out_addr), .level_o(level));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic is_dropped(input logic mesh, input logic [1:0] xy);
    logic drop;
    drop = mesh & (xy[1] ^ xy[0]);
`ifndef VDP1_MESH_EN
    drop = 1'b0;
`endif
    return drop;
  endfunction

  // Reference: integer per-channel arithmetic straight from the mode table.
  function automatic logic [PW-1:0] ref_color(input logic [2:0] ccb, input logic mon, input logic [PW-1:0] orig,
                                              input logic [PW-1:0] back, input logic [3*CW-1:0] grd);
    int o, k, g, og, a, b, r;
    logic om, bm, m;
    logic [PW-1:0] res;
    if (mon) return back | 16'h8000;
    om = orig[15];
    bm = back[15];
    res = '0;
    for (int c = 0; c < 3; c++) begin
      o = int'((orig >> (5*c)) & 16'd31);
      k = int'((back >> (5*c)) & 16'd31);
      g = int'((grd >> (5*c)) & 15'd31);
      og = o + g - 16;
      if (og < 0) og = 0;
      if (og > 31) og = 31;
      a = 0; b = 0;
      case (ccb)
        3'd0: a = o;
        3'd1: b = bm ? k / 2 : k;
        3'd2: a = o / 2;
        3'd3: begin a = bm ? o / 2 : o; b = bm ? k / 2 : 0; end
        3'd4: a = og;
        3'd5: b = k;
        3'd6: a = og / 2;
        default: begin a = bm ? og / 2 : og; b = bm ? k / 2 : 0; end
      endcase
      r = (a + b > 31) ? 31 : a + b;
      res = res | 16'(r << (5*c));
    end
    case (ccb)
      3'd1, 3'd5: m = bm;
      3'd3, 3'd6: m = bm | om;
      default:    m = om;
    endcase
    res[15] = m;
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ce) begin
      if (flush) exp_q.delete();
      else if (in_val && in_rdy) begin
        accepts++;
        if (!is_dropped(in_mesh, in_xy0))
          exp_q.push_back({in_addr, ref_color(in_ccb, in_mon, in_orig, in_back, in_grd)});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ce && !flush && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output actual=%0h required=none", {out_addr, out_color});
      end else begin
        check("out_pixel", 64'({out_addr, out_color}), 64'(exp_q.pop_front()));
        pops++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_pix();
    in_orig = 16'($urandom); in_back = 16'($urandom); in_ccb = 3'($urandom);
    in_mon = ($urandom_range(0, 3) == 0); in_grd = 15'($urandom); in_addr = 18'($urandom);
    in_mesh = 1'($urandom); in_xy0 = 2'($urandom);
  endtask

  task automatic send(input logic [2:0] ccb, input logic mon, input logic [PW-1:0] orig, input logic [PW-1:0] back,
                      input logic [3*CW-1:0] grd, input logic mesh, input logic [1:0] xy);
    logic got;
    in_ccb = ccb; in_mon = mon; in_orig = orig; in_back = back; in_grd = grd;
    in_addr = 18'($urandom); in_mesh = mesh; in_xy0 = xy; in_val = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk); got = in_rdy && ce && !flush;
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    if (!got) begin total++; bad++; $display("FAIL send_timeout actual=not_accepted required=accepted"); end
  endtask

  task automatic wait_out();
    for (int t = 0; t < 12 && !out_val; t++) tick();
    if (!out_val) begin total++; bad++; $display("FAIL out_timeout actual=0 required=1"); end
  endtask

  int a0, p0, exp_mesh;

  initial begin
    // Reset with garbage inputs
    for (int i = 0; i < 10; i++) begin
      rand_pix(); in_val = 1'($urandom); out_rdy = 1'($urandom); flush = 1'($urandom);
      tick();
      check("rst_in_rdy", 64'(in_rdy), 64'(1));
      check("rst_out_val", 64'(out_val), 64'(0));
      check("rst_level", 64'(level), 64'(0));
      check("rst_out_data", 64'({out_addr, out_color}), 64'(0));
    end
    in_val = 1'b0; flush = 1'b0; out_rdy = 1'b1; ce = 1'b1; in_mesh = 1'b0;
    rst_n = 1'b1;
    tick();

    // Gouraud with saturation and clamp, plus latency
    send(3'b100, 1'b0, {1'b0, 5'd16, 5'd5, 5'd20}, 16'($urandom), {5'd16, 5'd0, 5'd31}, 1'b0, 2'b00);
    check("lat_e1", 64'(out_val), 64'(0)); tick();
    check("lat_e2", 64'(out_val), 64'(0)); tick();
    check("lat_e3", 64'(out_val), 64'(0)); tick();
    check("lat_e4", 64'(out_val), 64'(1));
    check("gouraud_color", 64'(out_color), 64'h401F);
    check("gouraud_level", 64'(level), 64'(1));
    tick(); tick();

    send(3'b011, 1'b0, 16'h7FFF, 16'hC210, 15'($urandom), 1'b0, 2'b00);
    wait_out();
    check("half_blend_color", 64'(out_color), 64'hDEF7);
    tick(); tick();

    send(3'b011, 1'b1, 16'($urandom), 16'h1234, 15'($urandom), 1'b0, 2'b00);
    wait_out();
    check("msb_on_color", 64'(out_color), 64'h9234);
    tick(); tick();

    // Backpressure: credit limit
    out_rdy = 1'b0; a0 = accepts;
    for (int i = 0; i < 8; i++) begin rand_pix(); in_mesh = 1'b0; in_val = 1'b1; tick(); end
    in_val = 1'b0;
    check("bp_accepts", 64'(accepts - a0), 64'(4));
    check("bp_in_rdy", 64'(in_rdy), 64'(0));
    check("bp_level", 64'(level), 64'(4));
    p0 = pops; out_rdy = 1'b1;
    for (int t = 0; t < 20 && pops - p0 < 4; t++) tick();
    check("bp_pops", 64'(pops - p0), 64'(4));
    check("bp_in_rdy_again", 64'(in_rdy), 64'(1));
    check("bp_level_empty", 64'(level), 64'(0));

    // Flush with two pixels in flight and a simultaneous accept
    for (int i = 0; i < 2; i++) begin rand_pix(); in_mesh = 1'b0; in_val = 1'b1; tick(); end
    flush = 1'b1; rand_pix(); tick();
    flush = 1'b0; in_val = 1'b0;
    check("flush_level", 64'(level), 64'(0));
    check("flush_out_val", 64'(out_val), 64'(0));
    p0 = pops;
    for (int i = 0; i < 10; i++) tick();
    check("flush_no_output", 64'(pops - p0), 64'(0));

    // Flush of a full FIFO wins over a pop
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin rand_pix(); in_mesh = 1'b0; in_val = 1'b1; tick(); end
    in_val = 1'b0;
    check("full_level", 64'(level), 64'(4));
    p0 = pops; out_rdy = 1'b1; flush = 1'b1; tick(); flush = 1'b0;
    check("flush_full_level", 64'(level), 64'(0));
    check("flush_full_in_rdy", 64'(in_rdy), 64'(1));
    check("flush_full_no_pop", 64'(pops - p0), 64'(0));

    // Clock-enable freeze with an entry waiting at the head
    out_rdy = 1'b0;
    send(3'($urandom), 1'b0, 16'($urandom), 16'($urandom), 15'($urandom), 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) tick();
    ce = 1'b0; out_rdy = 1'b1; p0 = pops;
    for (int i = 0; i < 5; i++) tick();
    check("ce_level", 64'(level), 64'(1));
    check("ce_out_val", 64'(out_val), 64'(1));
    check("ce_no_pop", 64'(pops - p0), 64'(0));
    ce = 1'b1; tick();
    check("ce_resume_pop", 64'(pops - p0), 64'(1));

    // Mesh pixels
`ifdef VDP1_MESH_EN
    exp_mesh = 0;
`else
    exp_mesh = 1;
`endif
    p0 = pops; a0 = accepts;
    send(3'($urandom), 1'b0, 16'($urandom), 16'($urandom), 15'($urandom), 1'b1, 2'b01);
    for (int i = 0; i < 6; i++) tick();
    check("mesh_odd_outputs", 64'(pops - p0), 64'(exp_mesh));
    send(3'($urandom), 1'b0, 16'($urandom), 16'($urandom), 15'($urandom), 1'b1, 2'b00);
    for (int i = 0; i < 6; i++) tick();
    check("mesh_even_outputs", 64'(pops - p0), 64'(exp_mesh + 1));
    check("mesh_accepts", 64'(accepts - a0), 64'(2));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_pix();
      in_val = 1'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      ce = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 63) == 0);
      tick();
    end
    in_val = 1'b0; flush = 1'b0; ce = 1'b1; out_rdy = 1'b1;
    for (int t = 0; t < 30 && (exp_q.size() != 0 || out_val); t++) tick();
    check("drain_scoreboard", 64'(exp_q.size()), 64'(0));
    check("drain_level", 64'(level), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
